// File: rtl/pcie_x1_rx_pkg.sv
// Shared symbol codes, PIPE status codes and lane-sync state encoding for the x1 receive path.
package pcie_x1_rx_pkg;

  localparam logic [7:0] PCS_COMMA = 8'hBC;
  localparam logic [7:0] PCS_EDB   = 8'hFE;

  localparam logic [2:0] RXSTAT_OK       = 3'b000;
  localparam logic [2:0] RXSTAT_DEC_ERR  = 3'b100;
  localparam logic [2:0] RXSTAT_DISP_ERR = 3'b111;

  typedef enum logic [1:0] {
    LSM_LOS  = 2'd0,
    LSM_ACQ  = 2'd1,
    LSM_SYNC = 2'd2
  } lsm_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       cv;
    logic       disp_err;
  } rx_sym_t;

  function automatic logic is_comma(input rx_sym_t s);
    return s.k && (s.data == PCS_COMMA) && !s.cv && !s.disp_err;
  endfunction

  function automatic logic is_error(input rx_sym_t s);
    return s.cv || s.disp_err;
  endfunction

endpackage

// File: rtl/pcie_x1_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module pcie_x1_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic ff_rx_fclk_chx,
  input  logic RESET_n,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge ff_rx_fclk_chx or negedge RESET_n) begin
    if (!RESET_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/pcie_x1_rx_lsm.sv
// PCIe x1 receive lane-sync state machine: two-stage symbol pipe, comma acquisition,
// leaky-bucket error tracking, and PIPE RxData/RxStatus/RxValid generation.
module pcie_x1_rx_lsm
  import pcie_x1_rx_pkg::*;
#(
  parameter int unsigned COMMA_CNT = 4,
  parameter int unsigned ERR_MAX   = 4,
  parameter int unsigned GOOD_RUN  = 4
) (
  input  logic       ff_rx_fclk_chx,
  input  logic       RESET_n,
  input  logic [7:0] rx_data_in,
  input  logic       rx_k_in,
  input  logic       rx_cv_in,
  input  logic       rx_disp_err_in,
  input  logic       rx_ei_in,
  input  logic       lsm_enable,
  output logic [7:0] RxData_out,
  output logic       RxDataK_out,
  output logic [2:0] RxStatus_out,
  output logic       RxValid_out,
  output logic [1:0] lsm_state_out
);

  localparam int unsigned CW = $clog2(COMMA_CNT + 1);
  localparam int unsigned EW = $clog2(ERR_MAX + 1);
  localparam int unsigned GW = $clog2(GOOD_RUN + 1);

  logic ei_s;
  logic en_s;

  // Electrical idle resets to "idle" and enable to "disabled" so sync cannot start early.
  pcie_x1_sync2 #(.RST_VAL(1'b1)) u_sync_ei (
    .ff_rx_fclk_chx (ff_rx_fclk_chx),
    .RESET_n        (RESET_n),
    .d_in           (rx_ei_in),
    .q_out          (ei_s)
  );

  pcie_x1_sync2 #(.RST_VAL(1'b0)) u_sync_en (
    .ff_rx_fclk_chx (ff_rx_fclk_chx),
    .RESET_n        (RESET_n),
    .d_in           (lsm_enable),
    .q_out          (en_s)
  );

  rx_sym_t     s1_q,        s1_d;
  lsm_state_e  state_q,     state_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [EW-1:0] err_cnt_q,   err_cnt_d;
  logic [GW-1:0] good_cnt_q,  good_cnt_d;
  logic [7:0]  rx_data_q,   rx_data_d;
  logic        rx_k_q,      rx_k_d;
  logic [2:0]  rx_status_q, rx_status_d;
  logic        rx_valid_q,  rx_valid_d;

  logic sym_comma;
  logic sym_err;

  // Next-state, counter and output-stage computation on the stage-1 symbol.
  always_comb begin
    s1_d        = '{data: rx_data_in, k: rx_k_in, cv: rx_cv_in, disp_err: rx_disp_err_in};
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    sym_comma   = is_comma(s1_q);
    sym_err     = is_error(s1_q);

    if (ei_s || !en_s) begin
      state_d     = LSM_LOS;
      comma_cnt_d = '0;
      err_cnt_d   = '0;
      good_cnt_d  = '0;
    end else begin
      unique case (state_q)
        LSM_LOS: begin
          if (sym_comma) begin
            if (COMMA_CNT == 1) begin
              state_d     = LSM_SYNC;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
              good_cnt_d  = '0;
            end else begin
              state_d     = LSM_ACQ;
              comma_cnt_d = CW'(1);
            end
          end
        end
        LSM_ACQ: begin
          if (sym_err) begin
            state_d     = LSM_LOS;
            comma_cnt_d = '0;
          end else if (sym_comma) begin
            if (comma_cnt_q + CW'(1) == CW'(COMMA_CNT)) begin
              state_d     = LSM_SYNC;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
              good_cnt_d  = '0;
            end else begin
              comma_cnt_d = comma_cnt_q + CW'(1);
            end
          end
        end
        LSM_SYNC: begin
          if (sym_err) begin
            if (err_cnt_q + EW'(1) == EW'(ERR_MAX)) begin
              state_d     = LSM_LOS;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
              good_cnt_d  = '0;
            end else begin
              err_cnt_d  = err_cnt_q + EW'(1);
              good_cnt_d = '0;
            end
          end else if (good_cnt_q + GW'(1) == GW'(GOOD_RUN)) begin
            good_cnt_d = '0;
            err_cnt_d  = (err_cnt_q == '0) ? '0 : err_cnt_q - EW'(1);
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
          end
        end
        default: begin
          state_d     = LSM_LOS;
          comma_cnt_d = '0;
          err_cnt_d   = '0;
          good_cnt_d  = '0;
        end
      endcase
    end

    rx_data_d   = s1_q.cv ? PCS_EDB : s1_q.data;
    rx_k_d      = s1_q.cv | s1_q.k;
    rx_status_d = s1_q.cv       ? RXSTAT_DEC_ERR  :
                  s1_q.disp_err ? RXSTAT_DISP_ERR : RXSTAT_OK;
    rx_valid_d  = (state_d == LSM_SYNC);
  end

  always_ff @(posedge ff_rx_fclk_chx or negedge RESET_n) begin
    if (!RESET_n) begin
      s1_q        <= '0;
      state_q     <= LSM_LOS;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      good_cnt_q  <= '0;
      rx_data_q   <= '0;
      rx_k_q      <= 1'b0;
      rx_status_q <= RXSTAT_OK;
      rx_valid_q  <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_k_q      <= rx_k_d;
      rx_status_q <= rx_status_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign RxData_out    = rx_data_q;
  assign RxDataK_out   = rx_k_q;
  assign RxStatus_out  = rx_status_q;
  assign RxValid_out   = rx_valid_q;
  assign lsm_state_out = state_q;

endmodule

// File: tb/tb_pcie_x1_rx_lsm.sv
// Bench for pcie_x1_rx_lsm: directed vector table, hand sequences, and random symbols
// checked every cycle against a symbol-level lane-sync model.
module tb_pcie_x1_rx_lsm;

  localparam int NC = 4;
  localparam int NE = 4;
  localparam int NG = 4;

  logic       clk = 1'b0;
  logic       RESET_n;
  logic [7:0] d;
  logic       k, cv, ds, ei, en;
  logic [7:0] RxData_out;
  logic       RxDataK_out;
  logic [2:0] RxStatus_out;
  logic       RxValid_out;
  logic [1:0] lsm_state_out;

  always #5 clk = ~clk;

  pcie_x1_rx_lsm #(.COMMA_CNT(NC), .ERR_MAX(NE), .GOOD_RUN(NG)) dut (
    .ff_rx_fclk_chx (clk),
    .RESET_n        (RESET_n),
    .rx_data_in     (d),
    .rx_k_in        (k),
    .rx_cv_in       (cv),
    .rx_disp_err_in (ds),
    .rx_ei_in       (ei),
    .lsm_enable     (en),
    .RxData_out     (RxData_out),
    .RxDataK_out    (RxDataK_out),
    .RxStatus_out   (RxStatus_out),
    .RxValid_out    (RxValid_out),
    .lsm_state_out  (lsm_state_out)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: hunting phase counts clean commas, locked phase is a leaky error bucket.
  int         m_state, m_commas, m_errs, m_goods;
  logic [7:0] p_data;
  logic       p_k, p_cv, p_ds;
  logic [1:0] ei_h, en_h;
  logic [7:0] e_data;
  logic       e_k, e_valid;
  logic [2:0] e_status;

  always begin
    @(posedge clk or negedge RESET_n);
    if (!RESET_n) begin
      m_state = 0; m_commas = 0; m_errs = 0; m_goods = 0;
      p_data = 8'h00; p_k = 1'b0; p_cv = 1'b0; p_ds = 1'b0;
      ei_h = 2'b11; en_h = 2'b00;
      e_data = 8'h00; e_k = 1'b0; e_status = 3'b000; e_valid = 1'b0;
    end else begin
      bit comma, bad;
      comma = p_k && (p_data == 8'hBC) && !p_cv && !p_ds;
      bad   = p_cv || p_ds;
      if (ei_h[1] || !en_h[1]) begin
        m_state = 0; m_commas = 0; m_errs = 0; m_goods = 0;
      end else if (m_state != 2) begin
        if (bad) begin
          m_state = 0; m_commas = 0;
        end else if (comma) begin
          m_commas++;
          if (m_commas == NC) begin
            m_state = 2; m_errs = 0; m_goods = 0;
          end else begin
            m_state = 1;
          end
        end
      end else if (bad) begin
        m_errs++;
        m_goods = 0;
        if (m_errs == NE) begin
          m_state = 0; m_commas = 0; m_errs = 0;
        end
      end else begin
        m_goods++;
        if (m_goods == NG) begin
          m_goods = 0;
          if (m_errs > 0) m_errs--;
        end
      end
      e_valid  = (m_state == 2);
      e_data   = p_cv ? 8'hFE : p_data;
      e_k      = p_cv | p_k;
      e_status = p_cv ? 3'b100 : (p_ds ? 3'b111 : 3'b000);
      p_data = d; p_k = k; p_cv = cv; p_ds = ds;
      ei_h = {ei_h[0], ei};
      en_h = {en_h[0], en};
    end
  end

  always begin
    @(negedge clk);
    if (chk_on)
      chk("model", 32'({RxData_out, RxDataK_out, RxStatus_out, RxValid_out, lsm_state_out}),
                   32'({e_data, e_k, e_status, e_valid, 2'(m_state)}));
  end

  task automatic drive(input logic [7:0] dd, input logic kk, input logic c, input logic s);
    @(negedge clk);
    d = dd; k = kk; cv = c; ds = s;
  endtask

  task automatic comma_sym();
    drive(8'hBC, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle_sym();
    drive(8'h4A, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       k, cv, ds;
    logic [7:0] ed;
    logic       ek;
    logic [2:0] es;
    logic       ev;
    logic [1:0] est;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl[NV];

  task automatic row(input int i, input logic [7:0] dd, input logic kk, input logic c,
                     input logic s, input logic [7:0] ed, input logic ek, input logic [2:0] es,
                     input logic ev, input logic [1:0] est);
    tbl[i] = '{d: dd, k: kk, cv: c, ds: s, ed: ed, ek: ek, es: es, ev: ev, est: est};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Acquire, lose on 4th spaced disparity error, reacquire partially, cv in ACQ.
    row(0,  8'hBC, 1, 0, 0, 8'hBC, 1, 3'b000, 0, 2'd1);
    row(1,  8'hBC, 1, 0, 0, 8'hBC, 1, 3'b000, 0, 2'd1);
    row(2,  8'hBC, 1, 0, 0, 8'hBC, 1, 3'b000, 0, 2'd1);
    row(3,  8'hBC, 1, 0, 0, 8'hBC, 1, 3'b000, 1, 2'd2);
    row(4,  8'h4A, 0, 0, 0, 8'h4A, 0, 3'b000, 1, 2'd2);
    row(5,  8'h4A, 0, 0, 0, 8'h4A, 0, 3'b000, 1, 2'd2);
    row(6,  8'h55, 0, 0, 1, 8'h55, 0, 3'b111, 1, 2'd2);
    row(7,  8'h4A, 0, 0, 0, 8'h4A, 0, 3'b000, 1, 2'd2);
    row(8,  8'h4A, 0, 0, 0, 8'h4A, 0, 3'b000, 1, 2'd2);
    row(9,  8'h55, 0, 0, 1, 8'h55, 0, 3'b111, 1, 2'd2);
    row(10, 8'h4A, 0, 0, 0, 8'h4A, 0, 3'b000, 1, 2'd2);
    row(11, 8'h4A, 0, 0, 0, 8'h4A, 0, 3'b000, 1, 2'd2);
    row(12, 8'h55, 0, 0, 1, 8'h55, 0, 3'b111, 1, 2'd2);
    row(13, 8'h4A, 0, 0, 0, 8'h4A, 0, 3'b000, 1, 2'd2);
    row(14, 8'h4A, 0, 0, 0, 8'h4A, 0, 3'b000, 1, 2'd2);
    row(15, 8'h55, 0, 0, 1, 8'h55, 0, 3'b111, 0, 2'd0);
    row(16, 8'hBC, 1, 0, 0, 8'hBC, 1, 3'b000, 0, 2'd1);
    row(17, 8'hBC, 1, 0, 0, 8'hBC, 1, 3'b000, 0, 2'd1);
    row(18, 8'h33, 0, 1, 0, 8'hFE, 1, 3'b100, 0, 2'd0);
    row(19, 8'h4A, 0, 0, 0, 8'h4A, 0, 3'b000, 0, 2'd0);

    RESET_n = 1'b0;
    d = 8'h4A; k = 1'b0; cv = 1'b0; ds = 1'b0; ei = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data",   32'(RxData_out),    32'h00);
    chk("reset_k",      32'(RxDataK_out),   32'h0);
    chk("reset_status", 32'(RxStatus_out),  32'h0);
    chk("reset_valid",  32'(RxValid_out),   32'h0);
    chk("reset_state",  32'(lsm_state_out), 32'h0);
    chk_on = 1'b1;

    // Commas right after reset release: the first one lands while enable is still synchronizing.
    RESET_n = 1'b1;
    d = 8'hBC; k = 1'b1;
    repeat (3) comma_sym();
    idle_sym();
    idle_sym();
    chk("early_sync_valid", 32'(RxValid_out),   32'h0);
    chk("early_sync_state", 32'(lsm_state_out), 32'h1);
    drive(8'h33, 1'b0, 1'b1, 1'b0);
    repeat (3) idle_sym();

    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("vec%0d_data", i - 2),   32'(RxData_out),    32'(tbl[i-2].ed));
        chk($sformatf("vec%0d_k", i - 2),      32'(RxDataK_out),   32'(tbl[i-2].ek));
        chk($sformatf("vec%0d_status", i - 2), 32'(RxStatus_out),  32'(tbl[i-2].es));
        chk($sformatf("vec%0d_valid", i - 2),  32'(RxValid_out),   32'(tbl[i-2].ev));
        chk($sformatf("vec%0d_state", i - 2),  32'(lsm_state_out), 32'(tbl[i-2].est));
      end
      if (i < NV) begin
        d = tbl[i].d; k = tbl[i].k; cv = tbl[i].cv; ds = tbl[i].ds;
      end else begin
        d = 8'h4A; k = 1'b0; cv = 1'b0; ds = 1'b0;
      end
    end

    // Two errors drained by eight good symbols, then three more errors keep sync.
    repeat (4) comma_sym();
    repeat (2) drive(8'h55, 1'b0, 1'b0, 1'b1);
    repeat (8) idle_sym();
    repeat (3) drive(8'h55, 1'b0, 1'b0, 1'b1);
    idle_sym();
    idle_sym();
    chk("drain_valid", 32'(RxValid_out),   32'h1);
    chk("drain_state", 32'(lsm_state_out), 32'h2);

    // Electrical idle in SYNC drops valid within three cycles.
    @(negedge clk);
    ei = 1'b1;
    begin
      bit dropped;
      dropped = 1'b0;
      for (int c = 0; c < 3 && !dropped; c++) begin
        @(negedge clk);
        if (!RxValid_out) dropped = 1'b1;
      end
      chk("ei_drop", 32'(dropped), 32'h1);
    end
    ei = 1'b0;
    repeat (3) idle_sym();

    // Reset pulsed while acquiring.
    repeat (2) comma_sym();
    idle_sym();
    idle_sym();
    chk("pre_reset_acq", 32'(lsm_state_out), 32'h1);
    #2 RESET_n = 1'b0;
    #1;
    chk("mid_reset", 32'({RxData_out, RxDataK_out, RxStatus_out, RxValid_out, lsm_state_out}), 32'h0);
    @(negedge clk);
    RESET_n = 1'b1;

    // Random symbols with occasional idle and disable excursions.
    begin
      int ei_left, en_left, r;
      ei_left = 0; en_left = 0;
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        r = int'($urandom_range(0, 99));
        if (r < 35)      begin d = 8'hBC; k = 1'b1; cv = 1'b0; ds = 1'b0; end
        else if (r < 40) begin d = 8'($urandom); k = 1'($urandom); cv = 1'b1; ds = 1'($urandom); end
        else if (r < 45) begin d = (r < 43) ? 8'hBC : 8'($urandom); k = 1'b1; cv = 1'b0; ds = 1'b1; end
        else             begin d = 8'($urandom); k = (r < 48); cv = 1'b0; ds = 1'b0; end
        if (ei_left > 0) ei_left--;
        else if ($urandom_range(0, 299) == 0) ei_left = int'($urandom_range(1, 4));
        if (en_left > 0) en_left--;
        else if ($urandom_range(0, 499) == 0) en_left = int'($urandom_range(1, 5));
        ei = (ei_left > 0);
        en = (en_left == 0);
      end
    end
    repeat (4) idle_sym();

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_x1_rx_lsm.md
PCIE_X1_RX_LSM -- requirements
Module: pcie_x1_rx_lsm

Interface
REQ-001 Parameter COMMA_CNT, default 4: consecutive-error-free commas needed to acquire lane sync (range 1..15).
REQ-002 Parameter ERR_MAX, default 4: error count at which sync is lost (range 1..7).
REQ-003 Parameter GOOD_RUN, default 4: consecutive good symbols that decrement the error count (range 1..15).
REQ-004 ff_rx_fclk_chx  in  1  recovered receive clock; sole clock of the block.
REQ-005 RESET_n  in  1  reset, asynchronous, active-low.
REQ-006 rx_data_in  in  8  decoded symbol from the SERDES 8b/10b decoder.
REQ-007 rx_k_in  in  1  K-character flag for rx_data_in.
REQ-008 rx_cv_in  in  1  code violation on the current symbol.
REQ-009 rx_disp_err_in  in  1  disparity error on the current symbol.
REQ-010 rx_ei_in  in  1  raw electrical-idle detect, asynchronous to the clock.
REQ-011 lsm_enable  in  1  level input, asynchronous to the clock; low forces loss of sync.
REQ-012 RxData_out  out  8  symbol to the PIPE adaptation stage.
REQ-013 RxDataK_out  out  1  K flag aligned with RxData_out.
REQ-014 RxStatus_out  out  3  PIPE status aligned with RxData_out.
REQ-015 RxValid_out  out  1  lane-sync indication aligned with RxData_out.
REQ-016 lsm_state_out  out  2  current state encoding, for debug only.

Function
REQ-017 rx_ei_in and lsm_enable SHALL each pass through a two-flop synchronizer before use; ei_s and en_s denote the synchronized values.
REQ-018 Data path SHALL be two register stages, so every input symbol appears on RxData_out exactly 2 cycles later.
REQ-019 "Comma" SHALL mean rx_k_in=1, rx_data_in=8'hBC, rx_cv_in=0 and rx_disp_err_in=0; "error" SHALL mean rx_cv_in or rx_disp_err_in set.
REQ-020 The state machine SHALL evaluate the stage-1 symbol and use the states LOS=0, ACQ=1, SYNC=2.
REQ-021 In LOS, a comma SHALL move the machine to ACQ with comma_cnt=1; if COMMA_CNT=1, it SHALL move directly to SYNC.
REQ-022 In ACQ, an error SHALL move the machine to LOS with comma_cnt=0; each comma SHALL increment comma_cnt; the comma that makes comma_cnt equal COMMA_CNT SHALL move the machine to SYNC with err_cnt=0 and good_cnt=0; non-comma good symbols SHALL be ignored.
REQ-023 In SYNC, an error SHALL increment err_cnt and clear good_cnt.
REQ-024 In SYNC, a good symbol SHALL increment good_cnt; when good_cnt reaches GOOD_RUN, the machine SHALL decrement err_cnt (saturating at 0) and clear good_cnt in the same cycle.
REQ-025 In SYNC, the error that makes err_cnt equal ERR_MAX SHALL move the machine to LOS and clear all counters.
REQ-026 ei_s=1 or en_s=0 SHALL force LOS and clear all counters on the next edge from any state; this SHALL take priority over every other transition.
REQ-027 RxValid_out SHALL be registered from next_state==SYNC, so it rises together with the COMMA_CNT-th comma on RxData_out and falls together with the symbol that caused the loss.
REQ-028 RxStatus_out SHALL be 3'b100 if cv is set (cv takes priority), else 3'b111 if disparity error is set, else 3'b000; status is reported regardless of state.
REQ-029 A symbol with cv set SHALL be replaced on output by RxData_out=8'hFE (EDB) with RxDataK_out=1.
REQ-030 Counters SHALL be sized to their parameter maximum and SHALL never wrap.

Reset
REQ-031 While RESET_n=0: RxData_out=8'h00, RxDataK_out=0, RxStatus_out=3'b000, RxValid_out=0, state=LOS, all counters 0, both ei synchronizer flops 1, both enable synchronizer flops 0.
REQ-032 After RESET_n deasserts, at least 2 clock edges SHALL elapse before en_s can be 1, so no sync can be acquired earlier.

Structure
REQ-033 Package pcie_x1_rx_pkg SHALL hold PCS_COMMA=8'hBC, PCS_EDB=8'hFE, the status codes 3'b000/3'b100/3'b111, and the state encoding.
REQ-034 The two-flop synchronizer SHALL be sub-module pcie_x1_sync2, with a parameterized reset value, instantiated twice; everything else stays flat.

Verification
REQ-035 Enable=1, EI=0, four BC commas, then D-data -> RxValid_out rises in the same cycle the 4th comma appears on RxData_out, input-to-output latency = 2.
REQ-036 In ACQ after 2 commas, inject one cv -> RxData_out=FE, RxDataK_out=1, RxStatus_out=100, state returns to LOS, RxValid_out stays 0.
REQ-037 In SYNC, 3 disparity errors each separated by 2 good symbols -> RxStatus_out=111 on each error, RxValid_out stays 1; a 4th error -> RxValid_out falls with that symbol.
REQ-038 In SYNC, 2 errors followed by 8 good symbols -> err_cnt returns to 0; 3 further errors do not drop sync.
REQ-039 In SYNC, assert rx_ei_in -> RxValid_out falls within 3 cycles; RESET_n pulsed mid-ACQ -> all outputs take their reset values immediately.
